// File: rtl/vx_axi_ost_limiter_if.sv
// AXI4 bus bundle (AW/W/B/AR/R) used on both sides of the outstanding-transaction limiter.
// The master modport drives requests and the slave modport drives responses.
interface vx_axi_ost_limiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 512,
    parameter int TID_WIDTH  = 8
);
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [TID_WIDTH-1:0]    awid;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;

    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;

    logic                    bvalid;
    logic                    bready;
    logic [TID_WIDTH-1:0]    bid;
    logic [1:0]              bresp;

    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [TID_WIDTH-1:0]    arid;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;

    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rlast;
    logic [TID_WIDTH-1:0]    rid;
    logic [1:0]              rresp;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
        input  arready,
        input  rvalid, rdata, rlast, rid, rresp,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
        output arready,
        output rvalid, rdata, rlast, rid, rresp,
        input  rready
    );
endinterface

// File: rtl/vx_axi_ost_limiter.sv
// Per-bank AXI4 outstanding-transaction limiter: gates AR/AW on registered in-flight counts,
// passes every channel through with zero latency, and reports occupancy and sticky errors.
module vx_axi_ost_limiter #(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 512,
    parameter  int TID_WIDTH  = 8,
    parameter  int MAX_RD     = 16,
    parameter  int MAX_WR     = 16,
    localparam int MAX_LIM    = (MAX_RD > MAX_WR) ? MAX_RD : MAX_WR,
    localparam int CNTW       = $clog2(MAX_LIM + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    vx_axi_ost_limiter_if.slave   s_axi,
    vx_axi_ost_limiter_if.master  m_axi,
    output logic [CNTW-1:0]       rd_pending,
    output logic [CNTW-1:0]       wr_pending,
    output logic                  idle,
    output logic                  err_resp,
    output logic                  err_underflow
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [CNTW-1:0] rd_pending_q, rd_pending_d;
    logic [CNTW-1:0] wr_pending_q, wr_pending_d;
    logic            err_resp_q, err_resp_d;
    logic            err_underflow_q, err_underflow_d;

    logic wr_ok, rd_ok;
    logic aw_fire, b_fire, ar_fire, r_fire, rlast_fire;

    // Gates look only at the registered counts, so no ready ever reaches its own valid.
    assign wr_ok = (wr_pending_q < CNTW'(MAX_WR));
    assign rd_ok = (rd_pending_q < CNTW'(MAX_RD));

    assign m_axi.awvalid  = s_axi.awvalid & wr_ok;
    assign s_axi.awready  = m_axi.awready & wr_ok;
    assign m_axi.awaddr   = s_axi.awaddr[ADDR_WIDTH-1:0];
    assign m_axi.awid     = s_axi.awid[TID_WIDTH-1:0];
    assign m_axi.awlen    = s_axi.awlen;
    assign m_axi.awsize   = s_axi.awsize;
    assign m_axi.awburst  = s_axi.awburst;
    assign m_axi.awlock   = s_axi.awlock;
    assign m_axi.awcache  = s_axi.awcache;
    assign m_axi.awprot   = s_axi.awprot;
    assign m_axi.awqos    = s_axi.awqos;
    assign m_axi.awregion = s_axi.awregion;

    assign m_axi.wvalid   = s_axi.wvalid;
    assign s_axi.wready   = m_axi.wready;
    assign m_axi.wdata    = s_axi.wdata[DATA_WIDTH-1:0];
    assign m_axi.wstrb    = s_axi.wstrb[STRB_WIDTH-1:0];
    assign m_axi.wlast    = s_axi.wlast;

    assign s_axi.bvalid   = m_axi.bvalid;
    assign m_axi.bready   = s_axi.bready;
    assign s_axi.bid      = m_axi.bid;
    assign s_axi.bresp    = m_axi.bresp;

    assign m_axi.arvalid  = s_axi.arvalid & rd_ok;
    assign s_axi.arready  = m_axi.arready & rd_ok;
    assign m_axi.araddr   = s_axi.araddr[ADDR_WIDTH-1:0];
    assign m_axi.arid     = s_axi.arid[TID_WIDTH-1:0];
    assign m_axi.arlen    = s_axi.arlen;
    assign m_axi.arsize   = s_axi.arsize;
    assign m_axi.arburst  = s_axi.arburst;
    assign m_axi.arlock   = s_axi.arlock;
    assign m_axi.arcache  = s_axi.arcache;
    assign m_axi.arprot   = s_axi.arprot;
    assign m_axi.arqos    = s_axi.arqos;
    assign m_axi.arregion = s_axi.arregion;

    assign s_axi.rvalid   = m_axi.rvalid;
    assign m_axi.rready   = s_axi.rready;
    assign s_axi.rdata    = m_axi.rdata;
    assign s_axi.rlast    = m_axi.rlast;
    assign s_axi.rid      = m_axi.rid;
    assign s_axi.rresp    = m_axi.rresp;

    assign aw_fire    = s_axi.awvalid & m_axi.awready & wr_ok;
    assign ar_fire    = s_axi.arvalid & m_axi.arready & rd_ok;
    assign b_fire     = m_axi.bvalid & s_axi.bready;
    assign r_fire     = m_axi.rvalid & s_axi.rready;
    assign rlast_fire = r_fire & m_axi.rlast;

    // A retire at zero is an underflow and saturates, but a same-cycle issue still counts.
    function automatic logic [CNTW-1:0] next_count(input logic [CNTW-1:0] cnt,
                                                   input logic            inc,
                                                   input logic            dec);
        logic [CNTW-1:0] res;
        res = cnt;
        if (inc && !dec) begin
            res = cnt + CNTW'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            res = cnt - CNTW'(1);
        end else if (inc && dec && (cnt == '0)) begin
            res = CNTW'(1);
        end
        return res;
    endfunction

    always_comb begin
        rd_pending_d    = next_count(rd_pending_q, ar_fire, rlast_fire);
        wr_pending_d    = next_count(wr_pending_q, aw_fire, b_fire);
        err_resp_d      = err_resp_q
                        | (b_fire & (m_axi.bresp != 2'b00))
                        | (r_fire & (m_axi.rresp != 2'b00));
        err_underflow_d = err_underflow_q
                        | (b_fire & (wr_pending_q == '0))
                        | (rlast_fire & (rd_pending_q == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pending_q    <= '0;
            wr_pending_q    <= '0;
            err_resp_q      <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            rd_pending_q    <= rd_pending_d;
            wr_pending_q    <= wr_pending_d;
            err_resp_q      <= err_resp_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign rd_pending    = rd_pending_q;
    assign wr_pending    = wr_pending_q;
    assign idle          = (rd_pending_q == '0) && (wr_pending_q == '0);
    assign err_resp      = err_resp_q;
    assign err_underflow = err_underflow_q;
endmodule
